divider_iterative: RTL
======================

DIVIDER_ITERATIVE -- requirements
Module: divider_iterative

Interface
REQ-001 SHALL have parameter WIDTH_N, default 36, giving the dividend and quotient width.
REQ-002 SHALL have parameter WIDTH_D, default 18, giving the divisor and remainder width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in_valid  input  1  operands present on N and D.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 N  input  WIDTH_N  unsigned dividend.
REQ-008 D  input  WIDTH_D  unsigned divisor.
REQ-009 out_valid  output  1  Q and R hold a valid result.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 Q  output  WIDTH_N  unsigned quotient.
REQ-012 R  output  WIDTH_D  unsigned remainder.
REQ-013 div_zero  output  1  result came from a zero divisor; port exists only when DIVIDER_ERR_PORT_EN is defined.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-015 in_ready SHALL be 1 in IDLE only; out_valid SHALL be 1 in DONE only.
REQ-016 Acceptance SHALL occur on a rising edge where in_valid and in_ready are both 1; N and D SHALL be latched at that edge.
REQ-017 On acceptance with D nonzero, the FSM SHALL go IDLE->CALC and clear the partial-remainder register (WIDTH_D+1 bits).
REQ-018 Division SHALL be restoring, one quotient bit per CALC cycle, MSB first; the CALC phase SHALL last exactly WIDTH_N cycles.
REQ-019 Each CALC step: shift in the next dividend bit; if partial remainder >= D, subtract D and set the quotient bit to 1, otherwise set it to 0.
REQ-020 After the WIDTH_N-th CALC edge, Q and R SHALL be registered and the FSM SHALL enter DONE.
REQ-021 Latency from the acceptance edge to out_valid=1 SHALL be WIDTH_N+1 rising edges.
REQ-022 On acceptance with D==0, the FSM SHALL go IDLE->DONE on the acceptance edge, skipping CALC.
REQ-023 For a zero divisor: Q SHALL be all ones; R SHALL be N[WIDTH_D-1:0]; div_zero SHALL be 1 if the port is present.
REQ-024 For a nonzero divisor, Q and R SHALL satisfy N == Q*D + R with R < D.
REQ-025 In DONE, Q, R and div_zero SHALL stay stable while out_ready is 0, for any number of cycles.
REQ-026 In DONE with out_ready 1, the FSM SHALL return to IDLE on that edge; in_ready SHALL be 1 in the next cycle.
REQ-027 No back-to-back overlap: a new operand SHALL NOT be accepted in the same cycle a result is consumed.
REQ-028 in_valid SHALL be ignored in CALC and DONE, and N and D changes there SHALL NOT affect the result in progress.
REQ-029 Q and R SHALL hold their last values in IDLE and CALC; only the transition into DONE updates them.

Reset
REQ-030 When rst=1 at a rising edge, state SHALL become IDLE from any state, including mid-CALC or in DONE; any operation in progress SHALL be discarded.
REQ-031 Values after reset: Q=0, R=0, div_zero=0, out_valid=0, in_ready=1, internal registers 0.
REQ-032 rst SHALL take priority over every handshake event on the same edge.

Configuration
REQ-033 Macro DIVIDER_ERR_PORT_EN: when defined, the div_zero port and its register SHALL exist; div_zero SHALL be cleared on every nonzero-divisor result.
REQ-034 Without DIVIDER_ERR_PORT_EN: no div_zero port or register; zero-divisor Q/R behaviour SHALL be unchanged.

Verification
REQ-035 N=200, D=10, out_ready=1 -> out_valid after 37 edges; Q=20, R=0.
REQ-036 Sequential N=5535/D=45, then N=90001/D=300 -> Q=123 R=0, then Q=300 R=1; in_ready=0 throughout each CALC.
REQ-037 N=7, D=0 -> out_valid on the edge after acceptance; Q=36'hFFFFFFFFF, R=7, div_zero=1 (macro defined); the next result N=9, D=3 gives div_zero=0.
REQ-038 N=36'hFFFFFFFFF, D=1 -> Q=36'hFFFFFFFFF, R=0; N=1000, D=18'h3FFFF -> Q=0, R=1000.
REQ-039 out_ready held 0 for 10 cycles in DONE -> Q/R/out_valid stable; out_ready=1 -> IDLE on that edge, in_ready=1 in the next cycle.
REQ-040 rst=1 pulsed for one cycle at CALC cycle 10 -> IDLE next cycle, all outputs at reset values; a subsequent N=200, D=10 gives Q=20, R=0.

Source files
------------

// File: rtl/divider_iterative.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first; Q/R registered on entry to DONE.
// Latency: WIDTH_N+1 rising edges from acceptance to out_valid (1 edge for a zero divisor).
// Backpressure: single operation in flight; the result is held in DONE until out_ready, operands accepted only in IDLE.
// Optional feature: define DIVIDER_ERR_PORT_EN to add the div_zero output and its register.
module divider_iterative #(
  parameter int WIDTH_N = 36,
  parameter int WIDTH_D = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_N-1:0] N,
  input  logic [WIDTH_D-1:0] D,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_N-1:0] Q,
  output logic [WIDTH_D-1:0] R
`ifdef DIVIDER_ERR_PORT_EN
  ,
  output logic               div_zero
`endif
);

  localparam int CW = $clog2(WIDTH_N + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH_N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  // dvd starts as the latched dividend; quotient bits shift in from the bottom
  // as dividend bits leave the top, so it ends up holding the quotient.
  logic [WIDTH_N-1:0] dvd;
  logic [WIDTH_D-1:0] dsr;
  logic [WIDTH_D:0]   rem;
  logic [CW-1:0]      cnt;

  logic [WIDTH_D+1:0] shifted;
  logic [WIDTH_D+1:0] dsr_ext;
  logic               take;
  logic [WIDTH_D:0]   rem_next;
  logic [WIDTH_N-1:0] dvd_next;

  // One restoring step: shift in the next dividend bit, subtract when it fits.
  always_comb begin
    shifted  = {rem, dvd[WIDTH_N-1]};
    dsr_ext  = {2'b00, dsr};
    take     = (shifted >= dsr_ext);
    rem_next = (WIDTH_D+1)'(take ? (shifted - dsr_ext) : shifted);
    dvd_next = {dvd[WIDTH_N-2:0], take};
  end

`ifdef DIVIDER_ERR_PORT_EN
  logic dz_q;
  assign div_zero = dz_q;
`endif

  // Control FSM plus datapath registers; reset wins over every handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      dvd       <= '0;
      dsr       <= '0;
      rem       <= '0;
      cnt       <= '0;
      Q         <= '0;
      R         <= '0;
`ifdef DIVIDER_ERR_PORT_EN
      dz_q      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            dvd      <= N;
            dsr      <= D;
            rem      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            if (D == '0) begin
              // Zero divisor: report saturated quotient immediately.
              Q         <= '1;
              R         <= N[WIDTH_D-1:0];
              out_valid <= 1'b1;
              state     <= S_DONE;
`ifdef DIVIDER_ERR_PORT_EN
              dz_q      <= 1'b1;
`endif
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          dvd <= dvd_next;
          rem <= rem_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST_STEP) begin
            Q         <= dvd_next;
            R         <= rem_next[WIDTH_D-1:0];
            out_valid <= 1'b1;
            state     <= S_DONE;
`ifdef DIVIDER_ERR_PORT_EN
            dz_q      <= 1'b0;
`endif
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
